// File: rtl/secuencia_lectura_pkg.sv
// Shared definitions for the RTC bus sequencers: state encoding, strobe idle level,
// default phase length and the per-state strobe decode.
package secuencia_lectura_pkg;

  localparam logic STROBE_INACTIVO = 1'b1;
  localparam int   T_FASE_DEF      = 4;

  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    DIR_CS  = 3'd1,
    DIR_WR  = 3'd2,
    DIR_FIN = 3'd3,
    PAUSA   = 3'd4,
    DAT_CS  = 3'd5,
    DAT_RD  = 3'd6,
    DAT_FIN = 3'd7
  } estado_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic cs;
    logic ad;
    logic oe;
  } salidas_t;

  function automatic salidas_t decodificar(input estado_t estado);
    salidas_t s;
    s = '{rd: STROBE_INACTIVO, wr: STROBE_INACTIVO, cs: STROBE_INACTIVO,
          ad: STROBE_INACTIVO, oe: 1'b0};
    unique case (estado)
      DIR_CS, DIR_FIN: begin s.cs = ~STROBE_INACTIVO; s.ad = ~STROBE_INACTIVO; s.oe = 1'b1; end
      DIR_WR: begin
        s.cs = ~STROBE_INACTIVO; s.ad = ~STROBE_INACTIVO; s.wr = ~STROBE_INACTIVO; s.oe = 1'b1;
      end
      DAT_CS, DAT_FIN: s.cs = ~STROBE_INACTIVO;
      DAT_RD: begin s.cs = ~STROBE_INACTIVO; s.rd = ~STROBE_INACTIVO; end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/secuencia_lectura_if.sv
// Read-sequencer bus bundle: start request, address/data bus and active-low strobes.
interface secuencia_lectura_if #(parameter int largo = 8);
  logic             inicio;
  logic [largo-1:0] direccion;
  logic [largo-1:0] dato_bus_in;
  logic [largo-1:0] bus_out;
  logic             bus_oe;
  logic             RD_lectura;
  logic             WR_lectura;
  logic             CS_lectura;
  logic             AD_lectura;
  logic [largo-1:0] dato_leido;
  logic             listo;
  logic             ocupado;

  modport master (
    output inicio, direccion, dato_bus_in,
    input  bus_out, bus_oe, RD_lectura, WR_lectura, CS_lectura, AD_lectura,
           dato_leido, listo, ocupado
  );

  modport slave (
    input  inicio, direccion, dato_bus_in,
    output bus_out, bus_oe, RD_lectura, WR_lectura, CS_lectura, AD_lectura,
           dato_leido, listo, ocupado
  );
endinterface

// File: rtl/secuencia_lectura_contador_fase.sv
// Phase down-counter: reloads CUENTA-1 on carga, flags the last cycle of a phase with fin.
module contador_fase #(
  parameter int ANCHO  = 8,
  parameter int CUENTA = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic carga,
  output logic fin
);
  logic [ANCHO-1:0] cuenta;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)              cuenta <= '0;
    else if (carga)         cuenta <= ANCHO'(CUENTA - 1);
    else if (cuenta != '0)  cuenta <= cuenta - 1'b1;
  end

  assign fin = (cuenta == '0);
endmodule

// File: rtl/secuencia_lectura.sv
// RTC multiplexed read-cycle sequencer. Define SECUENCIA_SYNC_EN to pass the
// read-back bus through a 2-flop synchronizer before capture (needs T_FASE >= 3).
module secuencia_lectura
  import secuencia_lectura_pkg::*;
#(
  parameter int largo  = 8,
  parameter int T_FASE = T_FASE_DEF
) (
  input logic               clk,
  input logic               reset,
  secuencia_lectura_if.slave bus
);
  estado_t          estado, estado_sig;
  salidas_t         salidas;
  logic             fin, cambio;
  logic [largo-1:0] bus_out, dato_leido, dato_muestra;
  logic             listo, ocupado;

`ifdef SECUENCIA_SYNC_EN
  logic [largo-1:0] sinc1, sinc2;
  always_ff @(posedge clk) begin
    if (reset) begin
      sinc1 <= '0;
      sinc2 <= '0;
    end else begin
      sinc1 <= bus.dato_bus_in;
      sinc2 <= sinc1;
    end
  end
  assign dato_muestra = sinc2;
`else
  assign dato_muestra = bus.dato_bus_in;
`endif

  contador_fase #(.ANCHO(8), .CUENTA(T_FASE)) u_fase (
    .clk   (clk),
    .reset (reset),
    .carga (cambio),
    .fin   (fin)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    estado_sig = estado;
    unique case (estado)
      REPOSO:  if (bus.inicio) estado_sig = DIR_CS;
      DAT_FIN: if (fin)        estado_sig = REPOSO;
      default: if (fin)        estado_sig = estado_t'(estado + 3'd1);
    endcase
  end

  assign cambio = (estado_sig != estado);

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= REPOSO;
      salidas    <= decodificar(REPOSO);
      bus_out    <= '0;
      dato_leido <= '0;
      listo      <= 1'b0;
      ocupado    <= 1'b0;
    end else begin
      estado  <= estado_sig;
      salidas <= decodificar(estado_sig);
      ocupado <= (estado_sig != REPOSO);
      listo   <= (estado == DAT_FIN) && fin;
      if (estado == REPOSO && bus.inicio) bus_out <= bus.direccion;
      if (estado == DAT_RD && fin)        dato_leido <= dato_muestra;
    end
  end

  assign bus.bus_out    = bus_out;
  assign bus.bus_oe     = salidas.oe;
  assign bus.RD_lectura = salidas.rd;
  assign bus.WR_lectura = salidas.wr;
  assign bus.CS_lectura = salidas.cs;
  assign bus.AD_lectura = salidas.ad;
  assign bus.dato_leido = dato_leido;
  assign bus.listo      = listo;
  assign bus.ocupado    = ocupado;
endmodule

// File: tb/tb_secuencia_lectura.sv
// Self-checking bench for secuencia_lectura: cycle-indexed transaction model plus directed scenarios.
module tb_secuencia_lectura;
  localparam int LARGO = 8;
  localparam int T     = 4;
  localparam int TOT   = 7 * T;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  secuencia_lectura_if #(.largo(LARGO)) bus ();
  secuencia_lectura #(.largo(LARGO), .T_FASE(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ciclo = 0;

  // Model: pos = cycles since acceptance (1..TOT busy, TOT+1 done pulse, 0 idle).
  int         pos     = 0;
  logic [7:0] m_addr  = '0;
  logic [7:0] m_leido = '0;
  logic [7:0] hist0   = '0;
  logic [7:0] hist1   = '0;

  int listo_cnt, listo_at, wr_lo_cnt, rd_lo_cnt, ocup_lo_cnt, ocup_lo_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed=%h expected=%h", tag, ciclo, obs, exp);
    end
  endtask

  function automatic logic [31:0] observado();
    return {9'd0, bus.RD_lectura, bus.WR_lectura, bus.CS_lectura, bus.AD_lectura,
            bus.bus_oe, bus.listo, bus.ocupado, bus.bus_out, bus.dato_leido};
  endfunction

  function automatic logic [31:0] esperado();
    logic busy;
    int   p;
    busy = (pos >= 1) && (pos <= TOT);
    p    = busy ? (pos - 1) / T : -1;
    return {9'd0,
            !(busy && p == 5),            // RD
            !(busy && p == 1),            // WR
            !(busy && p != 3),            // CS
            !(busy && p <= 2),            // AD
            (busy && p <= 2),             // bus_oe
            (pos == TOT + 1),             // listo
            busy, m_addr, m_leido};
  endfunction

  task automatic paso(input logic ini, input logic [7:0] dir, input logic [7:0] dat,
                      input logic rst);
    logic [7:0] muestra;
    @(negedge clk);
    chk("salidas", observado(), esperado());
    chk("rd_wr_excl", {31'd0, ~(~bus.RD_lectura & ~bus.WR_lectura)}, 32'd1);
    if (bus.listo === 1'b1) begin listo_cnt++; listo_at = ciclo; end
    if (bus.WR_lectura === 1'b0) wr_lo_cnt++;
    if (bus.RD_lectura === 1'b0) rd_lo_cnt++;
    if (bus.ocupado === 1'b0) begin ocup_lo_cnt++; ocup_lo_at = ciclo; end
    bus.inicio      = ini;
    bus.direccion   = dir;
    bus.dato_bus_in = dat;
    reset           = rst;
    @(posedge clk);
`ifdef SECUENCIA_SYNC_EN
    muestra = hist1;
`else
    muestra = dat;
`endif
    if (rst) begin
      pos = 0; m_addr = '0; m_leido = '0;
    end else begin
      if (pos == 6 * T) m_leido = muestra;
      if ((pos == 0 || pos == TOT + 1) && ini) begin pos = 1; m_addr = dir; end
      else if (pos >= 1 && pos <= TOT) pos++;
      else pos = 0;
    end
    hist1 = hist0;
    hist0 = dat;
    ciclo++;
  endtask

  task automatic borrar_contadores();
    listo_cnt = 0; listo_at = -1; wr_lo_cnt = 0; rd_lo_cnt = 0; ocup_lo_cnt = 0; ocup_lo_at = -1;
  endtask

  initial begin
    int s;
    bus.inicio = 1'b0; bus.direccion = '0; bus.dato_bus_in = '0; reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset, then idle for 20 cycles.
    borrar_contadores();
    for (int i = 0; i < 20; i++) paso(1'b0, 8'($urandom), 8'($urandom), 1'b0);
    chk("idle_listo", 32'(listo_cnt), 32'd0);

    // Single transaction with a stray start request at cycle 10.
    borrar_contadores();
    s = ciclo;
    for (int i = 0; i < 35; i++) paso(i == 0 || i == 10, 8'h21, 8'h59, 1'b0);
    chk("t1_listo_cnt", 32'(listo_cnt), 32'd1);
    chk("t1_listo_at", 32'(listo_at - s), 32'd29);
    chk("t1_wr_low", 32'(wr_lo_cnt), 32'd4);
    chk("t1_rd_low", 32'(rd_lo_cnt), 32'd4);
    chk("t1_leido", 32'(bus.dato_leido), 32'h59);

    // Reset while RD is low.
    borrar_contadores();
    for (int i = 0; i < 22; i++) paso(i == 0, 8'h3C, 8'h77, 1'b0);
    paso(1'b0, 8'h3C, 8'h77, 1'b1);
    #1;
    chk("rst_strobes", {28'd0, bus.RD_lectura, bus.WR_lectura, bus.CS_lectura, bus.AD_lectura},
        32'hF);
    chk("rst_leido", 32'(bus.dato_leido), 32'd0);
    for (int i = 0; i < 20; i++) paso(1'b0, 8'h3C, 8'h77, 1'b0);
    chk("rst_no_listo", 32'(listo_cnt), 32'd0);

    // Back-to-back with start held high.
    borrar_contadores();
    s = ciclo;
    paso(1'b1, 8'hC3, 8'($urandom), 1'b0);
    ocup_lo_cnt = 0;
    for (int i = 1; i < 2 * TOT + 1; i++) paso(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    chk("b2b_ocup_low_cnt", 32'(ocup_lo_cnt), 32'd1);
    chk("b2b_ocup_low_at", 32'(ocup_lo_at - s), 32'd29);
    for (int i = 0; i < TOT + 5; i++) paso(1'b0, 8'($urandom), 8'($urandom), 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++)
      paso($urandom_range(7) == 0, 8'($urandom), 8'($urandom), $urandom_range(299) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/secuencia_lectura.md
# secuencia_lectura

Read-cycle sequencer for the RTC parallel address/data bus. On a start request it runs a full multiplexed read transaction (address phase, pause, data phase), drives the read-side strobes `RD_lectura`, `WR_lectura`, `CS_lectura` and `AD_lectura`, and captures the byte returned by the RTC. It sits directly upstream of the RD strobe multiplexer: `RD_lectura` feeds that mux's read input, and the other strobes feed the matching CS/WR/AD muxes.

## Interface
- `largo`, 8: data/address bus width.
- `T_FASE`, 4: clock cycles per phase; legal range 2..255, and 3..255 when `SECUENCIA_SYNC_EN` is defined.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inicio`  in  1  start request; sampled only in `REPOSO`.
- `direccion`  in  `largo`  RTC register address; latched when `inicio` is accepted.
- `dato_bus_in`  in  `largo`  RTC bus read-back value.
- `bus_out`  out  `largo`  address driven onto the bus.
- `bus_oe`  out  1  bus drive enable, 1 = drive.
- `RD_lectura`, `WR_lectura`, `CS_lectura`, `AD_lectura`  out  1 each  active-low strobes.
- `dato_leido`  out  `largo`  captured read data; holds its value until the next capture.
- `listo`  out  1  one-cycle done pulse.
- `ocupado`  out  1  transaction in progress.

## Operation
- Reset values:
  - strobes all 1, `bus_oe`=0, `bus_out`=0, `dato_leido`=0, `listo`=0, `ocupado`=0.
  - FSM in `REPOSO`, phase counter cleared.
- FSM sequence: `REPOSO` → `DIR_CS` → `DIR_WR` → `DIR_FIN` → `PAUSA` → `DAT_CS` → `DAT_RD` → `DAT_FIN` → `REPOSO`.
  - Each non-idle state lasts exactly `T_FASE` cycles.
  - The phase counter clears on every state change.
- Per-state outputs (strobes listed are low; all others are 1):
  - `DIR_CS`: `CS`, `AD` low; `bus_oe`=1.
  - `DIR_WR`: `CS`, `AD`, `WR` low; `bus_oe`=1.
  - `DIR_FIN`: `CS`, `AD` low; `bus_oe`=1.
  - `PAUSA`: no strobes low; `bus_oe`=0.
  - `DAT_CS`: `CS` low; `bus_oe`=0.
  - `DAT_RD`: `CS`, `RD` low; `bus_oe`=0.
  - `DAT_FIN`: `CS` low; `bus_oe`=0.
- `bus_out` holds the latched address from acceptance of `inicio` until the next acceptance.
- `RD_lectura` and `WR_lectura` are never low in the same cycle.
- Capture: `dato_leido` loads on the clock edge that ends the last cycle of `DAT_RD`, while RD is still low.
- `ocupado`=1 in every non-`REPOSO` state.
- `listo`=1 for one cycle on the first `REPOSO` cycle after `DAT_FIN`; `ocupado`=0 in that cycle.
- `inicio` is ignored while `ocupado`=1.
- `inicio`=1 in the same cycle that `listo`=1 is accepted, so transactions can run back-to-back.
- Reset mid-operation:
  - Next edge returns the FSM to `REPOSO` with reset values.
  - No `listo` pulse is produced.
  - `dato_leido` clears to 0.

## Timing
- All outputs are registered, decoded from the next-state value, so there are no combinational paths from inputs to outputs.
- Cycle numbering: `inicio` is sampled high at the edge ending cycle 0.
  - `DIR_CS` occupies cycles 1..T.
  - Each following state takes the next T cycles.
  - `listo` is high in cycle 7T+1.
- Total latency from `inicio` to `listo`: 7·`T_FASE`+1 cycles.
- `dato_leido` becomes valid in cycle 6T+1.

## Configuration
- `SECUENCIA_SYNC_EN` defined:
  - `dato_bus_in` passes through a 2-flop synchronizer before capture.
  - The captured value is the bus value two edges before the end of `DAT_RD`.
  - `T_FASE` must be ≥3.
- Undefined: `dato_bus_in` is sampled directly with no added flops.
- Latency to `listo` is unchanged in both builds.

## Structure
- Shared package holds:
  - state enumeration (3-bit encoding),
  - strobe idle-level constant (1'b1),
  - default `T_FASE`.
- One natural sub-module, `contador_fase`:
  - parameterized down-counter that emits a terminal-count pulse,
  - reused by the write-cycle sequencer.

## Test plan
- Reset then idle, `T_FASE`=4:
  - all strobes 1, `bus_oe`=0, `listo`/`ocupado`=0 for 20 cycles.
- `direccion`=8'h21, `dato_bus_in`=8'h59, `inicio` at cycle 0:
  - `WR` low in cycles 5..8, `RD` low in cycles 21..24.
  - `bus_out`=8'h21 with `bus_oe`=1 in cycles 1..12.
  - `dato_leido`=8'h59 from cycle 25; `listo` high in cycle 29 only.
- `inicio` pulsed again at cycle 10 during a transaction:
  - ignored; `listo` still only at cycle 29.
  - exactly one transaction is observed.
- `reset` asserted in cycle 22 while `RD` is low:
  - cycle 23 shows all strobes 1 and `dato_leido`=0.
  - no `listo` follows.
- Back-to-back: `inicio` held high continuously:
  - second `DIR_CS` starts in cycle 30.
  - `ocupado` is low only in cycle 29.
- With `SECUENCIA_SYNC_EN`, `T_FASE`=3, `dato_bus_in` changes 8'h00→8'hA5 at cycle 15:
  - `dato_leido`=8'hA5 in cycle 19.
